// File: rtl/scan_sequencer.sv
// Stepped DAC scan: for each step, load the DAC, settle, run one counter gate
// and hand the {code, step, count} result out through a valid/ready port.
module scan_sequencer #(
  parameter logic [7:0] BASE_ADDR = 8'h60,
  parameter int         SETTLE_W  = 16
) (
  input  logic        clock50Mhz,
  input  logic        reset,
  input  logic [7:0]  addr,
  input  logic [7:0]  data,
  input  logic        write,
  output logic [7:0]  data_out,
  output logic        dac_write32,
  output logic [31:0] dac_data32,
  input  logic        dac_busy,
  output logic        cnt_start,
  input  logic        cnt_done,
  input  logic [31:0] cnt_value,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic        busy,
  output logic        scan_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_DAC, S_SETTLE, S_COUNT, S_WAIT_CNT, S_EMIT, S_NEXT
  } state_t;

  state_t                state_q, state_d;
  logic [11:0]           code_q, code_d;
  logic [15:0]           step_idx_q, step_idx_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic                  dac_arm_q, dac_arm_d;
  logic                  dac_wr_q, dac_wr_d;
  logic [31:0]           dac_data_q, dac_data_d;
  logic                  cnt_start_q, cnt_start_d;
  logic                  res_valid_q, res_valid_d;
  logic [63:0]           res_data_q, res_data_d;
  logic                  scan_done_q, scan_done_d;
  logic [11:0]           start_q, start_d;
  logic [7:0]            step_q, step_d;
  logic [15:0]           nsteps_q, nsteps_d;
  logic [7:0]            settle_cfg_q, settle_cfg_d;

  logic [7:0]            off;
  logic                  ctrl_wr, start_cmd, abort_cmd;
  logic [SETTLE_W-1:0]   settle_load;

  function automatic logic [11:0] sat_add(input logic [11:0] c, input logic [7:0] s);
    logic [12:0] sum;
    sum = {1'b0, c} + {5'b0, s};
    return sum[12] ? 12'hFFF : sum[11:0];
  endfunction

  assign off         = addr - BASE_ADDR;
  assign ctrl_wr     = write && (off == 8'd6);
  // Abort outranks start when both bits arrive in one write.
  assign abort_cmd   = ctrl_wr && data[1];
  assign start_cmd   = ctrl_wr && data[0] && !data[1];
  assign settle_load = SETTLE_W'({settle_cfg_q, 8'h00});

  assign busy        = (state_q != S_IDLE);
  assign dac_write32 = dac_wr_q;
  assign dac_data32  = dac_data_q;
  assign cnt_start   = cnt_start_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign scan_done   = scan_done_q;

  always_comb begin
    data_out = 8'h00;
    case (off)
      8'd0:    data_out = start_q[7:0];
      8'd1:    data_out = {4'h0, start_q[11:8]};
      8'd2:    data_out = step_q;
      8'd3:    data_out = nsteps_q[7:0];
      8'd4:    data_out = nsteps_q[15:8];
      8'd5:    data_out = settle_cfg_q;
      8'd6:    data_out = {6'b0, busy, 1'b0};
      default: data_out = 8'h00;
    endcase
  end

  always_comb begin
    start_d      = start_q;
    step_d       = step_q;
    nsteps_d     = nsteps_q;
    settle_cfg_d = settle_cfg_q;
    if (write && state_q == S_IDLE) begin
      case (off)
        8'd0:    start_d[7:0]   = data;
        8'd1:    start_d[11:8]  = data[3:0];
        8'd2:    step_d         = data;
        8'd3:    nsteps_d[7:0]  = data;
        8'd4:    nsteps_d[15:8] = data;
        8'd5:    settle_cfg_d   = data;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    step_idx_d  = step_idx_q;
    settle_d    = settle_q;
    dac_arm_d   = dac_arm_q;
    dac_wr_d    = 1'b0;
    dac_data_d  = dac_data_q;
    cnt_start_d = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    scan_done_d = 1'b0;
    if (abort_cmd && state_q != S_IDLE) begin
      state_d     = S_IDLE;
      res_valid_d = 1'b0;
      scan_done_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (start_cmd) begin
          code_d     = start_q;
          step_idx_d = 16'd0;
          if (nsteps_q == 16'd0) scan_done_d = 1'b1;
          else                   state_d     = S_LOAD;
        end
        S_LOAD: begin
          dac_wr_d   = 1'b1;
          dac_data_d = {20'h0, code_q};
          dac_arm_d  = 1'b1;
          state_d    = S_WAIT_DAC;
        end
        // The first cycle gives the driver time to raise dac_busy.
        S_WAIT_DAC: begin
          if (dac_arm_q) begin
            dac_arm_d = 1'b0;
          end else if (!dac_busy) begin
            settle_d = settle_load;
            state_d  = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_q == '0) state_d  = S_COUNT;
          else                settle_d = settle_q - 1'b1;
        end
        S_COUNT: begin
          cnt_start_d = 1'b1;
          state_d     = S_WAIT_CNT;
        end
        S_WAIT_CNT: if (cnt_done) begin
          res_data_d  = {4'h0, code_q, step_idx_q, cnt_value};
          res_valid_d = 1'b1;
          state_d     = S_EMIT;
        end
        S_EMIT: if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_NEXT;
        end
        S_NEXT: begin
          if (step_idx_q + 16'd1 == nsteps_q) begin
            scan_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            step_idx_d = step_idx_q + 16'd1;
            code_d     = sat_add(code_q, step_q);
            state_d    = S_LOAD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock50Mhz or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      code_q       <= '0;
      step_idx_q   <= '0;
      settle_q     <= '0;
      dac_arm_q    <= 1'b0;
      dac_wr_q     <= 1'b0;
      dac_data_q   <= '0;
      cnt_start_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      scan_done_q  <= 1'b0;
      start_q      <= '0;
      step_q       <= 8'd1;
      nsteps_q     <= '0;
      settle_cfg_q <= '0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      step_idx_q   <= step_idx_d;
      settle_q     <= settle_d;
      dac_arm_q    <= dac_arm_d;
      dac_wr_q     <= dac_wr_d;
      dac_data_q   <= dac_data_d;
      cnt_start_q  <= cnt_start_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      scan_done_q  <= scan_done_d;
      start_q      <= start_d;
      step_q       <= step_d;
      nsteps_q     <= nsteps_d;
      settle_cfg_q <= settle_cfg_d;
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer with simple DAC-driver and counter models.
module tb_scan_sequencer;

  localparam logic [7:0] BASE = 8'h60;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  addr;
  logic [7:0]  data;
  logic        write;
  logic [7:0]  data_out;
  logic        dac_write32;
  logic [31:0] dac_data32;
  logic        dac_busy = 1'b0;
  logic        cnt_start;
  logic        cnt_done = 1'b0;
  logic [31:0] cnt_value = '0;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic        busy;
  logic        scan_done;

  int checks = 0;
  int errors = 0;

  logic [11:0] dac_log [64];
  logic [63:0] res_log [64];
  int n_dac = 0, n_res = 0, n_sd = 0, n_cnt = 0, cnt_base = 0;
  int dac_left = 0, cnt_left = 0;

  scan_sequencer #(.BASE_ADDR(BASE), .SETTLE_W(16)) dut (
    .clock50Mhz(clk), .reset(reset), .addr(addr), .data(data), .write(write),
    .data_out(data_out), .dac_write32(dac_write32), .dac_data32(dac_data32),
    .dac_busy(dac_busy), .cnt_start(cnt_start), .cnt_done(cnt_done),
    .cnt_value(cnt_value), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy), .scan_done(scan_done)
  );

  always #10 clk = ~clk;

  // DAC driver: busy for a few cycles after each load strobe.
  always @(negedge clk) begin
    if (dac_write32) dac_left = 3;
    else if (dac_left > 0) dac_left = dac_left - 1;
    dac_busy = (dac_left != 0);
  end

  // Counter gate: done a few cycles after start, value = (gate index in scan) * 7.
  always @(negedge clk) begin
    cnt_done = 1'b0;
    if (cnt_start) begin
      cnt_value = 32'((n_cnt - cnt_base) * 7);
      n_cnt     = n_cnt + 1;
      cnt_left  = 3;
    end else if (cnt_left > 0) begin
      cnt_left = cnt_left - 1;
      if (cnt_left == 0) cnt_done = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (dac_write32) begin
      if (n_dac < 64) dac_log[n_dac] = dac_data32[11:0];
      n_dac = n_dac + 1;
    end
    if (res_valid && res_ready) begin
      if (n_res < 64) res_log[n_res] = res_data;
      n_res = n_res + 1;
    end
    if (scan_done) n_sd = n_sd + 1;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    addr = a; data = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic cfg(input int start, input int step, input int nsteps, input int settle);
    bus_write(BASE + 8'd0, 8'(start));
    bus_write(BASE + 8'd1, 8'(start >> 8));
    bus_write(BASE + 8'd2, 8'(step));
    bus_write(BASE + 8'd3, 8'(nsteps));
    bus_write(BASE + 8'd4, 8'(nsteps >> 8));
    bus_write(BASE + 8'd5, 8'(settle));
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr = a; #1;
    chk(tag, data_out, exp);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    chk({tag, "_timeout"}, busy, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    int bd, br, bs, bc, n, bad;
    logic [63:0] exp_r;
    reset = 1'b1; addr = '0; data = '0; write = 1'b0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_outs", {res_valid, dac_write32, cnt_start, scan_done}, 0);
    chk("rst_resdata", res_data, 0);
    chk("rst_dacdata", dac_data32, 0);
    rd("rst_step", BASE + 8'd2, 8'd1);
    rd("rst_nsteps", BASE + 8'd3, 8'd0);
    @(negedge clk); reset = 1'b0;

    // Basic three-step scan with latency check.
    res_ready = 1'b1;
    cfg(100, 10, 3, 0);
    rd("rb_step", BASE + 8'd2, 8'd10);
    rd("rb_startl", BASE + 8'd0, 8'd100);
    rd("rb_outside_hi", 8'h67, 8'h00);
    rd("rb_outside_lo", 8'h5F, 8'h00);
    bd = n_dac; br = n_res; bs = n_sd; cnt_base = n_cnt;
    bus_write(BASE + 8'd6, 8'h01);
    chk("s1_busy", busy, 1);
    chk("s1_lat_load", dac_write32, 0);
    @(posedge clk); #1;
    chk("s1_lat_strobe", dac_write32, 1);
    chk("s1_dacword", dac_data32, 32'd100);
    wait_idle("s1");
    chk("s1_ndac", n_dac - bd, 3);
    chk("s1_code0", dac_log[bd], 12'd100);
    chk("s1_code1", dac_log[bd+1], 12'd110);
    chk("s1_code2", dac_log[bd+2], 12'd120);
    chk("s1_nres", n_res - br, 3);
    chk("s1_res0", res_log[br],   {4'h0, 12'd100, 16'd0, 32'd0});
    chk("s1_res1", res_log[br+1], {4'h0, 12'd110, 16'd1, 32'd7});
    chk("s1_res2", res_log[br+2], {4'h0, 12'd120, 16'd2, 32'd14});
    chk("s1_scandone", n_sd - bs, 1);

    // Saturation at the top of the code range.
    cfg(4090, 8, 3, 0);
    bd = n_dac; cnt_base = n_cnt;
    bus_write(BASE + 8'd6, 8'h01);
    wait_idle("s2");
    chk("s2_ndac", n_dac - bd, 3);
    chk("s2_code0", dac_log[bd], 12'd4090);
    chk("s2_code1", dac_log[bd+1], 12'd4095);
    chk("s2_code2", dac_log[bd+2], 12'd4095);

    // Zero-length scan.
    cfg(50, 1, 0, 0);
    bd = n_dac; bc = n_cnt;
    bus_write(BASE + 8'd6, 8'h01);
    chk("s3_done", scan_done, 1);
    chk("s3_busy", busy, 0);
    @(posedge clk); #1;
    chk("s3_done_off", scan_done, 0);
    repeat (10) @(posedge clk); #1;
    chk("s3_busy_later", busy, 0);
    chk("s3_nodac", n_dac - bd, 0);
    chk("s3_nocnt", n_cnt - bc, 0);

    // Back-pressure during EMIT.
    res_ready = 1'b0;
    cfg(5, 1, 2, 0);
    bd = n_dac; br = n_res; cnt_base = n_cnt;
    bus_write(BASE + 8'd6, 8'h01);
    n = 0;
    while (!res_valid && n < 200) begin @(negedge clk); n++; end
    chk("s4_valid_seen", res_valid, 1);
    exp_r = {4'h0, 12'd5, 16'd0, 32'd0};
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== exp_r) bad++;
    end
    chk("s4_stable", bad, 0);
    chk("s4_no_next_dac", n_dac - bd, 1);
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_idle("s4");
    chk("s4_nres", n_res - br, 2);
    chk("s4_res0", res_log[br], exp_r);
    chk("s4_res1", res_log[br+1], {4'h0, 12'd6, 16'd1, 32'd7});

    // Abort during SETTLE, ignored start/config while busy, then restart.
    cfg(7, 1, 2, 4);
    bd = n_dac; bs = n_sd; bc = n_cnt;
    bus_write(BASE + 8'd6, 8'h01);
    repeat (40) @(posedge clk); #1;
    chk("s5_in_settle", busy, 1);
    rd("s5_ctrl_busy", BASE + 8'd6, 8'h02);
    bus_write(BASE + 8'd6, 8'h01);
    bus_write(BASE + 8'd2, 8'd99);
    rd("s5_step_kept", BASE + 8'd2, 8'd1);
    chk("s5_no_restart", n_dac - bd, 1);
    bus_write(BASE + 8'd6, 8'h02);
    chk("s5_abort_idle", busy, 0);
    chk("s5_abort_done", scan_done, 1);
    repeat (20) @(posedge clk); #1;
    chk("s5_no_cnt", n_cnt - bc, 0);
    chk("s5_one_done", n_sd - bs, 1);
    chk("s5_dac_after", n_dac - bd, 1);
    bus_write(BASE + 8'd5, 8'd0);
    bd = n_dac; br = n_res; cnt_base = n_cnt;
    bus_write(BASE + 8'd6, 8'h01);
    wait_idle("s5b");
    chk("s5_restart_code", dac_log[bd], 12'd7);
    chk("s5_restart_res1", res_log[br+1], {4'h0, 12'd8, 16'd1, 32'd7});
    bs = n_sd;
    bus_write(BASE + 8'd6, 8'h03);
    chk("s5_both_busy", busy, 0);
    chk("s5_both_done", scan_done, 0);

    // Asynchronous reset in WAIT_CNT.
    cfg(20, 3, 2, 0);
    br = n_res; bc = n_cnt;
    bus_write(BASE + 8'd6, 8'h01);
    n = 0;
    while (n_cnt == bc && n < 200) begin @(negedge clk); n++; end
    chk("s6_reached_wait", n_cnt - bc, 1);
    bs = n_sd;
    #1 reset = 1'b1;
    #1;
    chk("s6_busy", busy, 0);
    chk("s6_outs", {res_valid, dac_write32, cnt_start, scan_done}, 0);
    chk("s6_resdata", res_data, 0);
    chk("s6_dacdata", dac_data32, 0);
    rd("s6_step_reset", BASE + 8'd2, 8'd1);
    rd("s6_start_reset", BASE + 8'd0, 8'd0);
    #2 reset = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("s6_no_done", n_sd - bs, 0);
    chk("s6_no_result", n_res - br, 0);
    chk("s6_still_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
